flap_input_conditioner: RTL and testbench

Conditions the raw game push-button into a clean, frame-aligned flap command for the flappy-bird game logic. Synchronises and debounces the pad input, detects presses, and holds each press as a pending request until the next frame boundary (falling edge of v_sync), then issues exactly one single-cycle flap pulse. It sits between the top-level button pin and the game controller's button input.

---
 rtl/flap_pkg.sv | 13 +
 rtl/btn_debounce.sv | 42 ++++
 rtl/flap_input_conditioner.sv | 101 ++++++++++
 tb/tb_flap_input_conditioner.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flap_pkg.sv
// Shared constants and state type for the flap input conditioner.
package flap_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 250000;
    localparam int REPEAT_FRAMES_DEF   = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        HELD    = 2'd2
    } flap_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus debounce counter: a new level is accepted only
// after it has been seen on sync2 for DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce
    import flap_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = 18
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button_in,
    output logic stable
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1 <= button_in;
            sync2 <= sync1;
            // Any sample matching the accepted level restarts the qualification.
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/flap_input_conditioner.sv
// Debounced button to frame-aligned single-cycle flap pulse.
// Optional feature macro: FLAP_AUTOREPEAT_EN (auto-repeat flaps while held).
module flap_input_conditioner
    import flap_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = 18,
    parameter int REPEAT_FRAMES   = REPEAT_FRAMES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button_in,
    input  logic v_sync,
    output logic flap,
    output logic button_level,
    output logic flap_pending
);

    logic        stable;
    logic        stable_d;
    logic        vs_d;
    logic        press;
    logic        tick;
    logic        rep_hit;
    logic        flap_d;
    flap_state_t state;
    flap_state_t state_next;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .button_in(button_in),
        .stable   (stable)
    );

    assign press        = stable & ~stable_d;
    assign tick         = vs_d & ~v_sync;
    assign button_level = stable;
    assign flap_pending = (state == PENDING);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_d <= 1'b0;
            vs_d     <= 1'b1;
            state    <= IDLE;
            flap     <= 1'b0;
        end else begin
            stable_d <= stable;
            vs_d     <= v_sync;
            state    <= state_next;
            flap     <= flap_d;
        end
    end

    always_comb begin
        state_next = state;
        flap_d     = tick & ((state == PENDING) | press | rep_hit);
        case (state)
            IDLE: begin
                if (press) state_next = tick ? HELD : PENDING;
            end
            PENDING: begin
                if (tick) state_next = HELD;
            end
            HELD: begin
                // A re-press after a release seen only in HELD must not be lost.
                if (press)        state_next = tick ? HELD : PENDING;
                else if (!stable) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef FLAP_AUTOREPEAT_EN
    localparam int FR_W = $clog2(REPEAT_FRAMES + 1);

    logic [FR_W-1:0] frame_cnt;

    // Counter holds the ticks seen since the last flap; the REPEAT_FRAMES-th tick repeats.
    assign rep_hit = (state == HELD) & stable & (frame_cnt == FR_W'(REPEAT_FRAMES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (flap_d || state_next != HELD) begin
            frame_cnt <= '0;
        end else if (tick) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end
`else
    logic repeat_unused;

    assign rep_hit       = 1'b0;
    assign repeat_unused = ^REPEAT_FRAMES;
`endif

endmodule

// File: tb/tb_flap_input_conditioner.sv
// Self-checking bench for flap_input_conditioner (DEBOUNCE_CYCLES=4, REPEAT_FRAMES=3).
module tb_flap_input_conditioner;

    localparam int DEB = 4;
    localparam int REP = 3;

    logic clk;
    logic rst_n;
    logic button_in;
    logic v_sync;
    logic flap;
    logic button_level;
    logic flap_pending;

    int checks;
    int errors;

    flap_input_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (3),
        .REPEAT_FRAMES  (REP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .button_in   (button_in),
        .v_sync      (v_sync),
        .flap        (flap),
        .button_level(button_level),
        .flap_pending(flap_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: input delay line, run-length acceptance, and a latched request.
    logic hist[$];
    int   m_run;
    logic m_lvl, m_lvl_d, m_vs_d, m_req, m_flap, m_active;
    int   m_frames;

    task automatic model_reset();
        hist     = {1'b0, 1'b0};
        m_run    = 0;
        m_lvl    = 1'b0;
        m_lvl_d  = 1'b0;
        m_vs_d   = 1'b1;
        m_req    = 1'b0;
        m_flap   = 1'b0;
        m_active = 1'b0;
        m_frames = 0;
    endtask

    task automatic model_step(input logic b, input logic v);
        logic samp, press, tick, rep, fl, act_n;
        samp  = hist.pop_front();
        hist.push_back(b);
        press = m_lvl & ~m_lvl_d;
        tick  = m_vs_d & ~v;
`ifdef FLAP_AUTOREPEAT_EN
        rep = tick & m_active & m_lvl & (m_frames == REP - 1);
`else
        rep = 1'b0;
`endif
        fl    = tick & (m_req | press | rep);
        m_req = tick ? 1'b0 : (m_req | press);
        act_n = fl | (m_active & m_lvl & ~press);
        if (fl || !act_n) m_frames = 0;
        else if (tick)    m_frames = m_frames + 1;
        m_active = act_n;
        m_lvl_d  = m_lvl;
        if (samp == m_lvl) begin
            m_run = 0;
        end else if (m_run == DEB - 1) begin
            m_lvl = samp;
            m_run = 0;
        end else begin
            m_run = m_run + 1;
        end
        m_vs_d = v;
        m_flap = fl;
    endtask

    // One clock: drive at the falling edge, model the rising edge, return at the next falling edge.
    task automatic cycle(input logic b, input logic v);
        button_in = b;
        v_sync    = v;
        @(posedge clk);
        model_step(b, v);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        button_in = 1'b0;
        v_sync    = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        button_in = 1'b1;
        v_sync    = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (flap !== 1'b0) begin
            errors++; $display("FAIL reset_flap got %b want 0", flap);
        end
        checks++;
        if (button_level !== 1'b0) begin
            errors++; $display("FAIL reset_level got %b want 0", button_level);
        end
        checks++;
        if (flap_pending !== 1'b0) begin
            errors++; $display("FAIL reset_pending got %b want 0", flap_pending);
        end
        apply_reset();
    endtask

    task automatic test_clean_press();
        int first_lvl, flap_cnt, flap_at, pend_first, pend_last;
        first_lvl = -1; flap_cnt = 0; flap_at = -1; pend_first = -1; pend_last = -1;
        apply_reset();
        for (int c = 1; c <= 60; c++) begin
            cycle(c <= 50, !(c >= 31 && c <= 33));
            if (button_level && first_lvl < 0) first_lvl = c;
            if (flap) begin flap_cnt++; flap_at = c; end
            if (flap_pending) begin
                if (pend_first < 0) pend_first = c;
                pend_last = c;
            end
        end
        checks++;
        if (first_lvl !== 6) begin errors++; $display("FAIL clean_level_cycle got %0d want 6", first_lvl); end
        checks++;
        if (flap_cnt !== 1) begin errors++; $display("FAIL clean_flap_count got %0d want 1", flap_cnt); end
        checks++;
        if (flap_at !== 31) begin errors++; $display("FAIL clean_flap_cycle got %0d want 31", flap_at); end
        checks++;
        if (pend_first !== 7) begin errors++; $display("FAIL clean_pending_first got %0d want 7", pend_first); end
        checks++;
        if (pend_last !== 30) begin errors++; $display("FAIL clean_pending_last got %0d want 30", pend_last); end
    endtask

    task automatic test_bounce();
        int first_lvl, flap_cnt, flap_at;
        first_lvl = -1; flap_cnt = 0; flap_at = -1;
        apply_reset();
        for (int c = 1; c <= 70; c++) begin
            cycle((c <= 20) ? (((c - 1) / 2) % 2 == 0) : 1'b1,
                  !((c >= 40 && c <= 41) || (c >= 60 && c <= 61)));
            if (button_level && first_lvl < 0) first_lvl = c;
            if (flap) begin flap_cnt++; flap_at = c; end
        end
        checks++;
        if (first_lvl !== 26) begin errors++; $display("FAIL bounce_level_cycle got %0d want 26", first_lvl); end
        checks++;
        if (flap_cnt !== 1) begin errors++; $display("FAIL bounce_flap_count got %0d want 1", flap_cnt); end
        checks++;
        if (flap_at !== 40) begin errors++; $display("FAIL bounce_flap_cycle got %0d want 40", flap_at); end
    endtask

    task automatic test_three_presses();
        int flap_cnt, flap_at;
        flap_cnt = 0; flap_at = -1;
        apply_reset();
        for (int c = 1; c <= 90; c++) begin
            cycle((c <= 48) ? (((c - 1) / 8) % 2 == 0) : 1'b0,
                  !((c >= 60 && c <= 61) || (c >= 80 && c <= 81)));
            if (flap) begin flap_cnt++; flap_at = c; end
        end
        checks++;
        if (flap_cnt !== 1) begin errors++; $display("FAIL three_flap_count got %0d want 1", flap_cnt); end
        checks++;
        if (flap_at !== 60) begin errors++; $display("FAIL three_flap_cycle got %0d want 60", flap_at); end
    endtask

    task automatic test_same_cycle();
        int flap_cnt, flap_at, pend_cnt;
        flap_cnt = 0; flap_at = -1; pend_cnt = 0;
        apply_reset();
        for (int c = 1; c <= 30; c++) begin
            cycle(1'b1, !(c == 7 || c == 8));
            if (flap) begin flap_cnt++; flap_at = c; end
            if (flap_pending) pend_cnt++;
        end
        checks++;
        if (flap_at !== 7) begin errors++; $display("FAIL same_flap_cycle got %0d want 7", flap_at); end
        checks++;
        if (flap_cnt !== 1) begin errors++; $display("FAIL same_flap_count got %0d want 1", flap_cnt); end
        checks++;
        if (pend_cnt !== 0) begin errors++; $display("FAIL same_pending_cycles got %0d want 0", pend_cnt); end
    endtask

    task automatic test_reset_pending();
        int flap_cnt, first_lvl;
        flap_cnt = 0; first_lvl = -1;
        apply_reset();
        for (int c = 1; c <= 12; c++) cycle(1'b1, 1'b1);
        checks++;
        if (flap_pending !== 1'b1) begin errors++; $display("FAIL rstp_pending_before got %b want 1", flap_pending); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (flap_pending !== 1'b0) begin errors++; $display("FAIL rstp_pending_async got %b want 0", flap_pending); end
        checks++;
        if (button_level !== 1'b0) begin errors++; $display("FAIL rstp_level_async got %b want 0", button_level); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            cycle(1'b1, !(c == 3 || c == 4));
            if (flap) flap_cnt++;
            if (button_level && first_lvl < 0) first_lvl = c;
        end
        checks++;
        if (flap_cnt !== 0) begin errors++; $display("FAIL rstp_flap_count got %0d want 0", flap_cnt); end
        checks++;
        if (first_lvl !== 6) begin errors++; $display("FAIL rstp_requalify_cycle got %0d want 6", first_lvl); end
    endtask

    task automatic test_autorepeat();
        int flap_cnt, first_flap, want_cnt;
        flap_cnt = 0; first_flap = -1;
`ifdef FLAP_AUTOREPEAT_EN
        want_cnt = 4;
`else
        want_cnt = 1;
`endif
        apply_reset();
        for (int c = 1; c <= 105; c++) begin
            cycle(1'b1, !(c % 10 == 0 || c % 10 == 1));
            if (flap) begin
                flap_cnt++;
                if (first_flap < 0) first_flap = c;
            end
        end
        checks++;
        if (flap_cnt !== want_cnt) begin errors++; $display("FAIL repeat_flap_count got %0d want %0d", flap_cnt, want_cnt); end
        checks++;
        if (first_flap !== 10) begin errors++; $display("FAIL repeat_first_flap got %0d want 10", first_flap); end
    endtask

    task automatic test_random();
        int   seg_left, frame_left;
        logic b, v;
        seg_left = 0; frame_left = 10; b = 1'b0; v = 1'b1;
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            if (seg_left == 0) begin
                b        = ($urandom_range(0, 2) != 0) ? ~b : b;
                seg_left = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 40);
            end
            seg_left--;
            if (frame_left == 0) frame_left = $urandom_range(8, 30);
            v = (frame_left > 2);
            frame_left--;
            cycle(b, v);
            checks++;
            if (flap !== m_flap) begin
                errors++; $display("FAIL rand_flap cyc %0d got %b want %b", c, flap, m_flap);
            end
            checks++;
            if (button_level !== m_lvl) begin
                errors++; $display("FAIL rand_level cyc %0d got %b want %b", c, button_level, m_lvl);
            end
            checks++;
            if (flap_pending !== m_req) begin
                errors++; $display("FAIL rand_pending cyc %0d got %b want %b", c, flap_pending, m_req);
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        button_in = 1'b0;
        v_sync    = 1'b1;
        model_reset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_three_presses();
        test_same_cycle();
        test_reset_pending();
        test_autorepeat();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
